// File: rtl/uart_rx.sv
// Serial receiver: start bit, 8 data bits MSB first, stop bit, idle-high line.
// Delivers each byte on a valid/ready port and flags bad stop bits and overruns.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  // START is entered one cycle after offset 0, so its counter reaches H-1 at offset H
  localparam logic [CW-1:0] START_LAST = CW'((H > 0) ? (H - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          load_s;

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (!rx) begin
          // With H = 0 the detecting cycle is itself the start sample
          if (H == 0) begin
            state_d = DATA;
          end else begin
            state_d = START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx) begin
            // A byte accepted in this same cycle frees the holding register
            if (!valid_q || ready) begin
              data_d = shift_q;
              load_s = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase

    if (load_s) begin
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: per-cycle vector table at one clock per bit,
// plus hand-written glitch and full-frame sequences at four clocks per bit.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;
  logic       rx4, ready4;
  logic [7:0] data4;
  logic       valid4, frame_err4, overrun4, busy4;

  int n_vec = 0;
  int n_err = 0;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .rx(rx4), .data(data4), .valid(valid4),
    .ready(ready4), .frame_err(frame_err4), .overrun(overrun4), .busy(busy4)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic        rx;
    logic        rdy;
    logic [11:0] e;   // {valid, data, frame_err, overrun, busy}
  } vec_t;

  vec_t vq[$];

  function automatic logic [11:0] ex(input logic v, input logic [7:0] d,
                                     input logic fe, input logic ov, input logic bz);
    return {v, d, fe, ov, bz};
  endfunction

  task automatic push(input logic rst, input logic r, input logic rdy, input logic [11:0] e);
    vec_t t;
    t.rst = rst;
    t.rx  = r;
    t.rdy = rdy;
    t.e   = e;
    vq.push_back(t);
  endtask

  task automatic idle(input int n, input logic rdy, input logic [11:0] e);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rdy, e);
  endtask

  task automatic bits(input logic [7:0] b, input logic rdy, input logic [11:0] e);
    for (int i = 0; i < 8; i++) push(1'b0, b[7-i], rdy, e);
  endtask

  task automatic check(input string name, input int idx, input logic [11:0] got,
                       input logic [11:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s #%0d: got v=%b d=%h fe=%b ov=%b busy=%b, expected v=%b d=%h fe=%b ov=%b busy=%b",
               name, idx, got[11], got[10:3], got[2], got[1], got[0],
               exp_v[11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    logic [11:0] z;
    logic [7:0]  b3c;
    logic [7:0]  b4;
    z   = 12'h000;
    b3c = 8'h3C;
    b4  = 8'h5A;

    // Single frame A5 with ready high
    idle(10, 1'b1, z);
    push(1'b0, 1'b0, 1'b1, z);
    bits(8'hA5, 1'b1, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b1, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b1, ex(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    idle(2, 1'b1, ex(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    push(1'b1, 1'b1, 1'b1, z);

    // Back-to-back A5 then 3C, ready low until cycle 25
    idle(10, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);
    bits(8'hA5, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      push(1'b0, b3c[7-i], (i >= 4), ex((i <= 4), 8'hA5, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b1, ex(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b1, ex(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0));
    push(1'b0, 1'b1, 1'b1, ex(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0));
    push(1'b1, 1'b1, 1'b0, z);

    // Overrun: 11 then 22 with ready low
    idle(3, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);
    bits(8'h11, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'h11, 1'b0, 1'b0, 1'b0));
    bits(8'h22, 1'b0, ex(1'b1, 8'h11, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h11, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h11, 1'b0, 1'b1, 1'b0));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h11, 1'b0, 1'b0, 1'b0));
    push(1'b1, 1'b1, 1'b0, z);

    // Framing error with nothing held, then a good 81, then a bad frame while 81 is held
    idle(2, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);
    bits(8'hFF, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b0, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    push(1'b0, 1'b1, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);
    bits(8'h81, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b0));
    push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b0));
    bits(8'hFF, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h81, 1'b1, 1'b0, 1'b0));
    push(1'b0, 1'b1, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b0));

    // Reset during data bit 4 of a 0F frame, then a clean C3 frame
    push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, ex(1'b1, 8'h81, 1'b0, 1'b0, 1'b1));
    push(1'b1, 1'b1, 1'b0, z);
    idle(4, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);
    bits(8'hC3, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b0, ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    push(1'b0, 1'b1, 1'b1, ex(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0));
    push(1'b0, 1'b1, 1'b1, ex(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0));

    ASYNCRESETN = 1'b0;
    rx = 1'b1; ready = 1'b0; rx4 = 1'b1; ready4 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_n1", 0, {valid, data, frame_err, overrun, busy}, z);
    check("reset_n4", 0, {valid4, data4, frame_err4, overrun4, busy4}, z);

    foreach (vq[i]) begin
      @(posedge CLK);
      #1;
      ASYNCRESETN = ~vq[i].rst;
      rx          = vq[i].rx;
      ready       = vq[i].rdy;
      @(negedge CLK);
      check("vec_n1", i, {valid, data, frame_err, overrun, busy}, vq[i].e);
    end

    // One-cycle low glitch: START at offset 1 samples high and aborts
    for (int o = 0; o < 8; o++) begin
      @(posedge CLK);
      #1;
      rx4 = (o == 0) ? 1'b0 : 1'b1;
      @(negedge CLK);
      check("glitch_n4", o, {valid4, data4, frame_err4, overrun4, busy4},
            ex(1'b0, 8'h00, 1'b0, 1'b0, (o == 1)));
    end

    // Full 5A frame at four clocks per bit; stop sampled at 37, valid at 38
    for (int o = 0; o < 42; o++) begin
      @(posedge CLK);
      #1;
      if (o < 4)       rx4 = 1'b0;
      else if (o < 36) rx4 = b4[7 - (o - 4) / 4];
      else             rx4 = 1'b1;
      @(negedge CLK);
      check("frame_n4", o, {valid4, data4, frame_err4, overrun4, busy4},
            ex((o >= 38), (o >= 38) ? 8'h5A : 8'h00, 1'b0, 1'b0, (o >= 1 && o <= 37)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
